// File: rtl/hbm_channel_port_pkg.sv
// Shared defaults and helpers for the HBM pseudo-channel port.
// Geometry defaults stand in for the accelerator-wide width and depth settings.
package hbm_channel_port_pkg;

    localparam int HBM_AWIDTH_DEF     = 32;
    localparam int HBM_DWIDTH_DEF     = 64;
    localparam int GROUP_CORE_NUM_DEF = 4;
    localparam int REQ_DEPTH_DEF      = 64;
    localparam int REQ_AF_MARGIN_DEF  = 8;
    localparam int RSP_DEPTH_DEF      = 64;

    localparam int ERR_REQ_OVF    = 0;
    localparam int ERR_RSP_NOCRED = 1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/hbm_port_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; the read port is combinational from the array
// so a pop and its data are consumed in the same cycle.
module hbm_port_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Full/empty come from registered pointers, so a push into a full FIFO is refused
    // even when a pop happens in the same cycle.
    assign push_ok  = push_i && !full_o;
    assign pop_ok   = pop_i && !empty_o;
    assign wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/hbm_channel_port.sv
// HBM pseudo-channel port: credit-controlled request issue and response broadcast to the core group.
// Define HBM_PORT_STATS_EN to add saturating issue/return/stall counters.
module hbm_channel_port
    import hbm_channel_port_pkg::*;
#(
    parameter int HBM_AWIDTH     = HBM_AWIDTH_DEF,
    parameter int HBM_DWIDTH     = HBM_DWIDTH_DEF,
    parameter int GROUP_CORE_NUM = GROUP_CORE_NUM_DEF,
    parameter int PSEUDO_ID      = 0,
    parameter int REQ_DEPTH      = REQ_DEPTH_DEF,
    parameter int REQ_AF_MARGIN  = REQ_AF_MARGIN_DEF,
    parameter int RSP_DEPTH      = RSP_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [HBM_AWIDTH-1:0]     front_rd_hbm_edge_addr,
    input  logic                      front_rd_hbm_edge_valid,
    output logic                      stage_full,
    input  logic                      hbm_controller_full,
    output logic [HBM_AWIDTH-1:0]     rd_hbm_edge_addr,
    output logic                      rd_hbm_edge_valid,
    input  logic [HBM_DWIDTH-1:0]     hbm_controller_edge,
    input  logic                      hbm_controller_valid,
    input  logic                      core_stall,
    output logic [HBM_DWIDTH-1:0]     active_v_edge,
    output logic [GROUP_CORE_NUM-1:0] active_v_edge_valid,
    output logic [1:0]                err,
`ifdef HBM_PORT_STATS_EN
    output logic [31:0]               stat_issued,
    output logic [31:0]               stat_returned,
    output logic [31:0]               stat_stall_cycles,
`endif
    output logic                      idle
);

    localparam int RQW = $clog2(REQ_DEPTH) + 1;
    localparam int RSW = $clog2(RSP_DEPTH) + 1;
    localparam int CW  = $clog2(RSP_DEPTH) + 1;
    localparam logic [CW-1:0]  CRED_MAX = CW'(RSP_DEPTH);
    localparam logic [RQW-1:0] AF_LEVEL = RQW'(REQ_DEPTH - REQ_AF_MARGIN);

    if (PSEUDO_ID < 0 || REQ_DEPTH < 4 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0 ||
        (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("hbm_channel_port: illegal depth or channel id parameter");
    end

    logic [HBM_AWIDTH-1:0] req_dout;
    logic [RQW-1:0]        req_count;
    logic                  req_empty, req_full;
    logic [HBM_DWIDTH-1:0] rsp_dout;
    logic [RSW-1:0]        rsp_count;
    logic                  rsp_empty, rsp_full;

    logic [CW-1:0]         credits_q, credits_d;
    logic [HBM_AWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_valid_q;
    logic [HBM_DWIDTH-1:0] edge_q, edge_d;
    logic                  edge_valid_q;
    logic [1:0]            err_q, err_d;
    logic                  issue, drain, rsp_accept, req_drop, rsp_drop;

    hbm_port_sync_fifo #(.WIDTH(HBM_AWIDTH), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (front_rd_hbm_edge_valid),
        .din_i   (front_rd_hbm_edge_addr),
        .pop_i   (issue),
        .dout_o  (req_dout),
        .count_o (req_count),
        .empty_o (req_empty),
        .full_o  (req_full)
    );

    hbm_port_sync_fifo #(.WIDTH(HBM_DWIDTH), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_accept),
        .din_i   (hbm_controller_edge),
        .pop_i   (drain),
        .dout_o  (rsp_dout),
        .count_o (rsp_count),
        .empty_o (rsp_empty),
        .full_o  (rsp_full)
    );

    // A credit is held from issue until the returned line leaves the response FIFO, so
    // RSP_DEPTH credits bound in-flight plus buffered lines to the FIFO capacity.
    assign issue      = !req_empty && !hbm_controller_full && (credits_q != '0);
    assign drain      = !rsp_empty && !core_stall;
    assign rsp_accept = hbm_controller_valid && (credits_q != CRED_MAX) && !rsp_full;
    assign rsp_drop   = hbm_controller_valid && !rsp_accept;
    assign req_drop   = front_rd_hbm_edge_valid && req_full;

    always_comb begin
        credits_d = credits_q;
        case ({issue, drain})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
        rd_addr_d = issue ? req_dout : rd_addr_q;
        edge_d    = drain ? rsp_dout : edge_q;
        err_d     = err_q;
        err_d[ERR_REQ_OVF]    = err_q[ERR_REQ_OVF] | req_drop;
        err_d[ERR_RSP_NOCRED] = err_q[ERR_RSP_NOCRED] | rsp_drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q    <= CRED_MAX;
            rd_addr_q    <= '0;
            rd_valid_q   <= 1'b0;
            edge_q       <= '0;
            edge_valid_q <= 1'b0;
            err_q        <= '0;
        end else begin
            credits_q    <= credits_d;
            rd_addr_q    <= rd_addr_d;
            rd_valid_q   <= issue;
            edge_q       <= edge_d;
            edge_valid_q <= drain;
            err_q        <= err_d;
        end
    end

    assign stage_full          = (req_count >= AF_LEVEL);
    assign rd_hbm_edge_addr    = rd_addr_q;
    assign rd_hbm_edge_valid   = rd_valid_q;
    assign active_v_edge       = edge_q;
    assign active_v_edge_valid = {GROUP_CORE_NUM{edge_valid_q}};
    assign err                 = err_q;
    assign idle = req_empty && rsp_empty && (credits_q == CRED_MAX) && !rd_valid_q && !edge_valid_q;

`ifdef HBM_PORT_STATS_EN
    logic [31:0] st_issued_q, st_returned_q, st_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_issued_q   <= '0;
            st_returned_q <= '0;
            st_stall_q    <= '0;
        end else begin
            st_issued_q   <= sat_inc32(st_issued_q, issue);
            st_returned_q <= sat_inc32(st_returned_q, rsp_accept);
            st_stall_q    <= sat_inc32(st_stall_q, !req_empty && !issue);
        end
    end

    assign stat_issued       = st_issued_q;
    assign stat_returned     = st_returned_q;
    assign stat_stall_cycles = st_stall_q;
`endif

endmodule
